// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  localparam int DEF_N          = 24;
  localparam int DEF_AW         = 14;
  localparam int DEF_LAST_ADDR  = 1024;
  localparam int DBG_MAX_GRANTS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_AW-1:0] pc;
    logic [DEF_N-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_controller_fetch_buffer.sv
// Two-entry prefetch FIFO; entry 0 is always the head. Flush beats push and pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t e0, e1;
  logic   do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else if (count == 2'd1) e1 <= din;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = (count != 2'd0) ? e0 : '0;

endmodule

// File: rtl/instruction_fetch_controller.sv
// PC owner and fetch sequencer for the single-port instruction memory.
// Optional debug read arbitration is compiled in with IFC_DEBUG_PORT_EN.
//   state | meaning
//   IDLE  | not fetching; buffer still drains
//   RUN   | one fetch per cycle while the buffer has room
//   HALT  | pc ran past LAST_ADDR; only a redirect resumes
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int AW        = DEF_AW,
  parameter int RESET_PC  = 0,
  parameter int LAST_ADDR = DEF_LAST_ADDR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_data,
  output logic          inst_valid,
  output logic [N-1:0]  inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
`ifdef IFC_DEBUG_PORT_EN
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic [N-1:0]  dbg_data,
`endif
  output logic          halted
);

  localparam logic [AW-1:0] LAST_PC  = AW'(LAST_ADDR);
  localparam logic [AW-1:0] RESET_VAL = AW'(RESET_PC);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [N-1:0]  instr;
  } entry_t;

  state_e        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [1:0]    count;
  logic          fetch_ok, fetch, pop, dbg_win;
  entry_t        head, push_entry;

  assign fetch_ok = (state == RUN) && (count != 2'd2) && !redirect_valid;

`ifdef IFC_DEBUG_PORT_EN
  // Grants left before fetch gets a forced turn; reloads on any non-granted cycle.
  logic [2:0] dbg_left;

  assign dbg_win = dbg_req && !(fetch_ok && (dbg_left == 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_left <= 3'(DBG_MAX_GRANTS);
    else if (!dbg_win) dbg_left <= 3'(DBG_MAX_GRANTS);
    else if (dbg_left != 3'd0) dbg_left <= dbg_left - 3'd1;
  end

  assign dbg_gnt   = dbg_win;
  assign dbg_data  = imem_data;
  assign imem_addr = dbg_win ? dbg_addr : pc;
`else
  assign dbg_win   = 1'b0;
  assign imem_addr = pc;
`endif

  assign fetch      = fetch_ok && !dbg_win;
  assign pop        = inst_valid && inst_ready;
  assign push_entry = '{pc: pc, instr: imem_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_VAL;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
      if (state != IDLE) state_nxt = (redirect_pc <= LAST_PC) ? RUN : HALT;
    end else begin
      if (fetch) pc_nxt = pc + AW'(1);
      case (state)
        IDLE:    if (fetch_en) state_nxt = RUN;
        RUN: begin
          if (fetch && (pc == LAST_PC)) state_nxt = HALT;
          else if (!fetch_en) state_nxt = IDLE;
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  fetch_buffer #(.entry_t(entry_t)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign inst_valid = (count != 2'd0);
  assign inst_data  = head.instr;
  assign inst_pc    = head.pc;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Scoreboard bench: expected retire PCs are queued with the stimulus and popped on each handshake.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [13:0] redirect_pc = '0;
  logic [13:0] imem_addr;
  logic [23:0] imem_data;
  logic        inst_valid;
  logic [23:0] inst_data;
  logic [13:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        halted;
`ifdef IFC_DEBUG_PORT_EN
  logic        dbg_req = 1'b0;
  logic [13:0] dbg_addr = '0;
  logic        dbg_gnt;
  logic [23:0] dbg_data;
`endif

  int errors = 0;
  int checks = 0;
  int sb[$];

  always #5 clk = ~clk;

  function automatic logic [23:0] mem_word(input logic [13:0] a);
    return {10'h155, a};
  endfunction

  assign imem_data = mem_word(imem_addr);

  instruction_fetch_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
`ifdef IFC_DEBUG_PORT_EN
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_gnt        (dbg_gnt),
    .dbg_data       (dbg_data),
`endif
    .halted         (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Retire monitor: a handshake during a redirect cycle is discarded by the flush.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_retire", 32'(inst_pc), 32'hFFFF_FFFF);
      end else begin
        int exp_pc;
        exp_pc = sb.pop_front();
        check_eq("retire_pc", 32'(inst_pc), exp_pc);
        check_eq("retire_data", 32'(inst_data), 32'(mem_word(exp_pc[13:0])));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
`ifdef IFC_DEBUG_PORT_EN
    dbg_req = 1'b0;
    dbg_addr = '0;
`endif
    sb.delete();
    step();
    check_eq("rst_valid", 32'(inst_valid), 0);
    check_eq("rst_data", 32'(inst_data), 0);
    check_eq("rst_pc", 32'(inst_pc), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_addr", 32'(imem_addr), 0);
`ifdef IFC_DEBUG_PORT_EN
    check_eq("rst_gnt", 32'(dbg_gnt), 0);
`endif
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Startup and back-to-back streaming
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    step();
    check_eq("start_no_valid_yet", 32'(inst_valid), 0);
    step();
    check_eq("start_valid", 32'(inst_valid), 1);
    check_eq("start_pc", 32'(inst_pc), 0);
    for (int i = 0; i < 8; i++) sb.push_back(i);
    for (int i = 0; i < 8; i++) begin
      check_eq("stream_valid", 32'(inst_valid), 1);
      step();
    end
    inst_ready = 1'b0;
    fetch_en = 1'b0;
    check_eq("stream_drain", 32'(sb.size()), 0);

    // Backpressure: buffer fills, pc holds, then drains in order
    do_reset();
    fetch_en = 1'b1;
    step(6);
    check_eq("stall_valid", 32'(inst_valid), 1);
    check_eq("stall_head", 32'(inst_pc), 0);
    check_eq("stall_pc", 32'(imem_addr), 2);
    step();
    check_eq("stall_pc_hold", 32'(imem_addr), 2);
    for (int i = 0; i < 4; i++) sb.push_back(i);
    inst_ready = 1'b1;
    step();
    check_eq("release_pc_hold", 32'(imem_addr), 2);
    check_eq("release_head", 32'(inst_pc), 1);
    step(3);
    inst_ready = 1'b0;
    check_eq("release_drain", 32'(sb.size()), 0);

    // Redirect flushes buffered 5,6
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 14'd5;
    step();
    check_eq("idle_redirect_pc", 32'(imem_addr), 5);
    check_eq("idle_redirect_valid", 32'(inst_valid), 0);
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    step(3);
    check_eq("prefill_head", 32'(inst_pc), 5);
    check_eq("prefill_pc", 32'(imem_addr), 7);
    redirect_valid = 1'b1;
    redirect_pc = 14'h100;
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check_eq("redir_bubble", 32'(inst_valid), 0);
    for (int i = 0; i < 3; i++) sb.push_back(32'h100 + i);
    step();
    check_eq("redir_valid", 32'(inst_valid), 1);
    check_eq("redir_pc", 32'(inst_pc), 32'h100);
    step(3);
    inst_ready = 1'b0;
    check_eq("redir_drain", 32'(sb.size()), 0);

    // End of memory, halt, out-of-range redirect, resume
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 14'd1023;
    sb.push_back(1023);
    sb.push_back(1024);
    step();
    redirect_valid = 1'b0;
    step();
    check_eq("end_head", 32'(inst_pc), 1023);
    step();
    check_eq("end_halted", 32'(halted), 1);
    check_eq("end_last_head", 32'(inst_pc), 1024);
    check_eq("end_pc", 32'(imem_addr), 1025);
    step(3);
    check_eq("halt_hold", 32'(halted), 1);
    check_eq("halt_empty", 32'(inst_valid), 0);
    check_eq("halt_pc", 32'(imem_addr), 1025);
    check_eq("halt_drain", 32'(sb.size()), 0);
    redirect_valid = 1'b1;
    redirect_pc = 14'd2000;
    step();
    redirect_valid = 1'b0;
    check_eq("oor_halted", 32'(halted), 1);
    check_eq("oor_pc", 32'(imem_addr), 2000);
    step();
    check_eq("oor_empty", 32'(inst_valid), 0);
    sb.push_back(0);
    sb.push_back(1);
    redirect_valid = 1'b1;
    redirect_pc = 14'd0;
    step();
    redirect_valid = 1'b0;
    check_eq("resume_run", 32'(halted), 0);
    step();
    check_eq("resume_valid", 32'(inst_valid), 1);
    check_eq("resume_pc", 32'(inst_pc), 0);
    step(2);
    inst_ready = 1'b0;
    check_eq("resume_drain", 32'(sb.size()), 0);

    // Asynchronous reset with a full buffer
    do_reset();
    fetch_en = 1'b1;
    step(5);
    check_eq("pre_async_valid", 32'(inst_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(inst_valid), 0);
    check_eq("async_pc", 32'(inst_pc), 0);
    check_eq("async_addr", 32'(imem_addr), 0);
    step();
    sb.push_back(0);
    sb.push_back(1);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    step();
    check_eq("restart_no_valid", 32'(inst_valid), 0);
    step();
    check_eq("restart_valid", 32'(inst_valid), 1);
    check_eq("restart_pc", 32'(inst_pc), 0);
    step(2);
    inst_ready = 1'b0;
    check_eq("restart_drain", 32'(sb.size()), 0);

`ifdef IFC_DEBUG_PORT_EN
    // Debug arbitration: four grants then one forced fetch turn
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) sb.push_back(i);
    for (int i = 1; i <= 10; i++) begin
      dbg_req = 1'b1;
      dbg_addr = 14'(32'h200 + i);
      #1;
      check_eq("dbg_gnt", 32'(dbg_gnt), (i % 5 != 0) ? 1 : 0);
      if (i % 5 != 0) begin
        check_eq("dbg_addr", 32'(imem_addr), 32'(dbg_addr));
        check_eq("dbg_data", 32'(dbg_data), 32'(mem_word(dbg_addr)));
      end else begin
        check_eq("dbg_fetch_addr", 32'(imem_addr), (i == 5) ? 0 : 1);
      end
      step();
    end
    dbg_req = 1'b0;
    step(3);
    inst_ready = 1'b0;
    check_eq("dbg_drain", 32'(sb.size()), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

Sequences the single-read-port instruction memory for the pipelined core: owns the program counter, issues one combinational read per cycle, and queues fetched words with their PCs in a 2-entry prefetch buffer toward decode over a valid/ready handshake. It sits between the instruction memory (14-bit address, 24-bit word, addresses 0..1024) and the decode stage. It handles branch redirects with a flush, and halts at the end of memory. Optionally it arbitrates the memory port with a debug/loader read requester.

## Interface
- `N`, 24, instruction width
- `AW`, 14, address width
- `RESET_PC`, 0, PC value loaded on reset
- `LAST_ADDR`, 1024, highest valid instruction address
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `fetch_en`  in  1  allows fetching while high
- `redirect_valid`  in  1  branch/jump redirect request, single-cycle pulse
- `redirect_pc`  in  AW  redirect target
- `imem_addr`  out  AW  instruction memory address (combinational)
- `imem_data`  in  N  instruction memory read data, combinational from `imem_addr`
- `inst_valid`  out  1  buffer head valid
- `inst_data`  out  N  buffer head instruction
- `inst_pc`  out  AW  buffer head PC
- `inst_ready`  in  1  decode accepts head
- `halted`  out  1  high in HALT state
- `dbg_req`, `dbg_addr` (AW), `dbg_gnt`, `dbg_data` (N): debug read port, present only with `IFC_DEBUG_PORT_EN`

## Operation
- FSM states: IDLE, RUN, HALT. Reset → IDLE.
- IDLE → RUN when `fetch_en`=1.
- RUN → IDLE when `fetch_en`=0. Buffer contents are retained and still drain.
- RUN → HALT on the edge that pushes address `LAST_ADDR`. `pc` becomes `LAST_ADDR`+1; nothing further is fetched.
- HALT → RUN on `redirect_valid`. In HALT, `fetch_en` is ignored.
- Fetch condition: state RUN, `count`<2, no redirect this cycle, no debug grant this cycle.
  - On fetch: `imem_addr`=`pc`. At the edge, push {`pc`, `imem_data`} and set `pc`←`pc`+1.
  - When not fetching, `imem_addr`=`pc`.
- Pop: `inst_valid` && `inst_ready`. A pop and a push in the same cycle leave `count` unchanged.
- Redirect (any state) has top priority:
  - Buffer flushed (`count`←0, pop ignored), `pc`←`redirect_pc`, no push that cycle.
  - From IDLE: stays IDLE.
  - From RUN or HALT: goes to RUN if `redirect_pc`≤`LAST_ADDR`, else HALT.
- `inst_valid` = `count`≠0. `inst_data`/`inst_pc` show the head entry and are 0 when empty.
- PC arithmetic is AW-bit unsigned. The HALT transition prevents wrap past `LAST_ADDR`.

## Timing
- Reset values: `pc`=`RESET_PC`, `count`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `halted`=0, `dbg_gnt`=0, `imem_addr`=`RESET_PC`.
- Reset asserted mid-operation clears the buffer and FSM immediately, without waiting for a clock edge.
- Startup: `fetch_en` sampled high at edge k → state RUN after k. Fetch during cycle k+1, `inst_valid`=1 after edge k+1.
- Steady state with `inst_ready`=1: one instruction per cycle, `count` stays at 1.
- Redirect at edge k: `inst_valid`=0 after k, target fetched in cycle k+1, target valid after k+1. Penalty is 2 cycles.
- `inst_ready`=0 with `count`=2: fetch stalls and `pc` holds.

## Configuration
- `IFC_DEBUG_PORT_EN` defined:
  - Debug port exists.
  - `dbg_req`=1 wins the memory port: `imem_addr`=`dbg_addr`, `dbg_gnt`=1 combinationally, `dbg_data`=`imem_data`, and the fetch is suppressed that cycle.
  - A starvation counter limits debug to 4 consecutive grants. The 5th cycle goes to fetch if the fetch condition holds, otherwise debug is granted. The counter resets on any non-granted cycle.
  - Redirect does not block the debug grant.
- Undefined: no debug ports, no counter. Fetch owns `imem_addr` at all times.

## Structure
- Package `fetch_pkg`:
  - FSM enum (IDLE/RUN/HALT)
  - default `AW`, `N`, `LAST_ADDR`
  - `DBG_MAX_GRANTS`=4
  - buffer entry struct {pc, instr}
- Sub-module `fetch_buffer`: 2-entry FIFO with push, pop, flush, and count. Flush has priority over push and pop.

## Test plan
- Reset, `fetch_en`=1, `inst_ready`=1, memory[i]=i → decode receives (pc 0, 0), (1, 1), (2, 2)… back-to-back, the first valid 2 edges after `fetch_en`.
- `inst_ready`=0 for 5 cycles after start → `count` saturates at 2, `pc`=2 holds; on release, PCs 0, 1, 2 arrive in order with no loss or duplication.
- Redirect to 0x100 while the buffer holds PCs 5, 6 and `inst_ready`=1 → 5 and 6 never retire after the redirect edge; next retired PC is 0x100 after a 2-cycle bubble.
- Redirect to 1023 → retires 1023 and 1024, then `halted`=1. Later redirect to 0 resumes fetch at 0.
- `rst_n` dropped asynchronously mid-stream with `count`=2 → `inst_valid`=0 immediately; after release, fetch restarts at `RESET_PC`.
- With `IFC_DEBUG_PORT_EN`, `dbg_req` held for 10 cycles during RUN → `dbg_gnt` pattern 1,1,1,1,0 repeating. Fetch advances one PC per 0-cycle, and `dbg_data` matches memory[`dbg_addr`].
